aes_128_keyexp_writer: RTL and testbench

//  Write side of the AES-128 round-key RAM. Takes a 128-bit cipher key and runs FIPS-197 key expansion.

---
 rtl/aes_128_pkg.sv | 48 ++++
 rtl/aes_128_keyexp_writer_if.sv | 25 ++
 rtl/aes_128_keyexp_sbox.sv | 18 +
 rtl/aes_128_keyexp_writer.sv | 104 ++++++++++
 tb/tb_aes_128_keyexp_writer.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/aes_128_pkg.sv
// Shared AES-128 definitions for the key-expansion datapath.
//   state_e     : key-writer FSM encoding (state = half currently on the write port)
//   NR          : number of rounds, KEY_HALVES : 64-bit halves written per key
//   rcon(i)     : round constant for expansion step i (1..10)
//   sbox(b)     : forward AES S-box byte lookup
package aes_128_pkg;

  localparam int unsigned NR         = 10;
  localparam int unsigned KEY_HALVES = 22;

  typedef enum logic [1:0] {StIdle, StWrHi, StWrLo, StDone} state_e;

  // Row-major forward S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[8 * (255 - int'(b)) +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    r = 8'h00;
    unique case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_128_keyexp_writer_if.sv
// Key-load / key-RAM write bundle for aes_128_keyexp_writer.
//   key_load, key_in                    : load request from the key source (master drives)
//   en_wr, addr_wr, key_round_wr        : key-RAM write port (slave drives)
//   key_ready, busy                     : expansion status (slave drives)
interface aes_128_keyexp_writer_if;

  logic         key_load;
  logic [127:0] key_in;
  logic         en_wr;
  logic [4:0]   addr_wr;
  logic [63:0]  key_round_wr;
  logic         key_ready;
  logic         busy;

  modport master (
    output key_load, key_in,
    input  en_wr, addr_wr, key_round_wr, key_ready, busy
  );

  modport slave (
    input  key_load, key_in,
    output en_wr, addr_wr, key_round_wr, key_ready, busy
  );

endinterface

// File: rtl/aes_128_keyexp_sbox.sv
// Combinational 32-bit SubWord: four parallel S-box byte lookups.
//   din  : input word
//   dout : substituted word
module aes_128_keyexp_sbox
  import aes_128_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);

  always_comb begin
    dout = '0;
    for (int i = 0; i < 4; i++) begin
      dout[8*i +: 8] = sbox(din[8*i +: 8]);
    end
  end

endmodule

// File: rtl/aes_128_keyexp_writer.sv
// AES-128 key expansion feeding the round-key RAM write port.
// Streams round keys 0..10 as 22 64-bit halves (high half first), one per cycle, then
// raises key_ready until the next key_load or reset.
//   clk    : clock, rising edge
//   kill_n : synchronous active-low reset
//   bus    : key-load inputs and key-RAM write/status outputs (slave side)
module aes_128_keyexp_writer
  import aes_128_pkg::*;
#(
  parameter logic [4:0] ADDR_BASE = 5'd0
) (
  input logic                      clk,
  input logic                      kill_n,
  aes_128_keyexp_writer_if.slave   bus
);

  state_e       state_q;
  logic [3:0]   rnd_q;
  logic [127:0] kreg_q;
  logic         en_wr_q;
  logic [4:0]   addr_wr_q;
  logic [63:0]  key_round_wr_q;
  logic         key_ready_q;
  logic         busy_q;

  logic [3:0]   rnd_nxt;
  logic [31:0]  rot_w3;
  logic [31:0]  sub_w3;
  logic [31:0]  t_word;
  logic [127:0] kreg_nxt;

  assign rnd_nxt = rnd_q + 4'd1;
  assign rot_w3  = {kreg_q[23:0], kreg_q[31:24]};

  aes_128_keyexp_sbox u_sbox (
    .din  (rot_w3),
    .dout (sub_w3)
  );

  always_comb begin
    t_word             = sub_w3 ^ {rcon(rnd_nxt), 24'h0};
    kreg_nxt           = '0;
    kreg_nxt[127:96]   = kreg_q[127:96] ^ t_word;
    kreg_nxt[95:64]    = kreg_q[95:64]  ^ kreg_nxt[127:96];
    kreg_nxt[63:32]    = kreg_q[63:32]  ^ kreg_nxt[95:64];
    kreg_nxt[31:0]     = kreg_q[31:0]   ^ kreg_nxt[63:32];
  end

  // state_q names the half currently presented on the write port, so the load edge
  // already registers the first write and the port is busy from the very next cycle.
  always_ff @(posedge clk) begin
    if (!kill_n) begin
      state_q        <= StIdle;
      rnd_q          <= '0;
      kreg_q         <= '0;
      en_wr_q        <= 1'b0;
      addr_wr_q      <= '0;
      key_round_wr_q <= '0;
      key_ready_q    <= 1'b0;
      busy_q         <= 1'b0;
    end else if (bus.key_load) begin
      state_q        <= StWrHi;
      rnd_q          <= '0;
      kreg_q         <= bus.key_in;
      en_wr_q        <= 1'b1;
      addr_wr_q      <= ADDR_BASE;
      key_round_wr_q <= bus.key_in[127:64];
      key_ready_q    <= 1'b0;
      busy_q         <= 1'b1;
    end else begin
      unique case (state_q)
        StWrHi: begin
          state_q        <= StWrLo;
          en_wr_q        <= 1'b1;
          addr_wr_q      <= ADDR_BASE + {rnd_q, 1'b1};
          key_round_wr_q <= kreg_q[63:0];
        end
        StWrLo: begin
          if (rnd_q == 4'(NR)) begin
            state_q     <= StDone;
            en_wr_q     <= 1'b0;
            key_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            state_q        <= StWrHi;
            rnd_q          <= rnd_nxt;
            kreg_q         <= kreg_nxt;
            en_wr_q        <= 1'b1;
            addr_wr_q      <= ADDR_BASE + {rnd_nxt, 1'b0};
            key_round_wr_q <= kreg_nxt[127:64];
          end
        end
        default: en_wr_q <= 1'b0;
      endcase
    end
  end

  assign bus.en_wr        = en_wr_q;
  assign bus.addr_wr      = addr_wr_q;
  assign bus.key_round_wr = key_round_wr_q;
  assign bus.key_ready    = key_ready_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_aes_128_keyexp_writer.sv
// Directed bench for aes_128_keyexp_writer: two instances (ADDR_BASE 0 and 10) run the same
// stimulus. Expected round keys come from FIPS-197 constants and an independent model whose
// S-box is derived from GF(2^8) inversion at time zero.
module tb_aes_128_keyexp_writer;

  logic clk;
  logic kill_n;
  int   n_checks;
  int   n_errors;

  aes_128_keyexp_writer_if bus_a ();
  aes_128_keyexp_writer_if bus_b ();

  aes_128_keyexp_writer #(.ADDR_BASE(5'd0)) dut_a (
    .clk    (clk),
    .kill_n (kill_n),
    .bus    (bus_a)
  );

  aes_128_keyexp_writer #(.ADDR_BASE(5'd10)) dut_b (
    .clk    (clk),
    .kill_n (kill_n),
    .bus    (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]   sb [256];
  logic [127:0] fips_rk [11];
  logic [127:0] zero_rk [11];
  logic [127:0] rand_rk [11];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_sched(input logic [127:0] key, output logic [127:0] rk [11]);
    logic [127:0] k;
    logic [31:0]  t;
    logic [7:0]   rc;
    k  = key;
    rc = 8'h01;
    rk[0] = k;
    for (int i = 1; i <= 10; i++) begin
      t = {sb[k[23:16]], sb[k[15:8]], sb[k[7:0]], sb[k[31:24]]} ^ {rc, 24'h0};
      k[127:96] = k[127:96] ^ t;
      k[95:64]  = k[95:64] ^ k[127:96];
      k[63:32]  = k[63:32] ^ k[95:64];
      k[31:0]   = k[31:0] ^ k[63:32];
      rk[i] = k;
      rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
    end
  endtask

  // Drives a 1-cycle load; returns at the sample point of the first write cycle.
  task automatic load_key(input logic [127:0] key);
    bus_a.key_load = 1'b1;
    bus_b.key_load = 1'b1;
    bus_a.key_in   = key;
    bus_b.key_in   = key;
    @(negedge clk);
    bus_a.key_load = 1'b0;
    bus_b.key_load = 1'b0;
    bus_a.key_in   = ~key;
    bus_b.key_in   = ~key;
  endtask

  task automatic expect_writes(input logic [127:0] rk [11], input int n);
    logic [63:0] d;
    for (int i = 0; i < n; i++) begin
      d = (i % 2 == 1) ? rk[i/2][63:0] : rk[i/2][127:64];
      check_eq("a_en", 64'(bus_a.en_wr), 64'd1);
      check_eq("a_addr", 64'(bus_a.addr_wr), 64'(i));
      check_eq("a_data", bus_a.key_round_wr, d);
      check_eq("a_busy", 64'(bus_a.busy), 64'd1);
      check_eq("a_ready_low", 64'(bus_a.key_ready), 64'd0);
      check_eq("b_en", 64'(bus_b.en_wr), 64'd1);
      check_eq("b_addr", 64'(bus_b.addr_wr), 64'(i + 10));
      check_eq("b_data", bus_b.key_round_wr, d);
      if (i < n - 1) @(negedge clk);
    end
  endtask

  task automatic expect_done();
    @(negedge clk);
    check_eq("a_ready", 64'(bus_a.key_ready), 64'd1);
    check_eq("a_busy_done", 64'(bus_a.busy), 64'd0);
    check_eq("a_en_done", 64'(bus_a.en_wr), 64'd0);
    check_eq("b_ready", 64'(bus_b.key_ready), 64'd1);
    check_eq("b_en_done", 64'(bus_b.en_wr), 64'd0);
  endtask

  task automatic expect_quiet(input string tag);
    check_eq({tag, "_en"}, 64'(bus_a.en_wr | bus_b.en_wr), 64'd0);
    check_eq({tag, "_ready"}, 64'(bus_a.key_ready | bus_b.key_ready), 64'd0);
    check_eq({tag, "_busy"}, 64'(bus_a.busy | bus_b.busy), 64'd0);
  endtask

  initial begin
    logic        seen;
    logic [127:0] rkey;
    n_checks = 0;
    n_errors = 0;
    kill_n = 1'b0;
    bus_a.key_load = 1'b0;
    bus_b.key_load = 1'b0;
    bus_a.key_in   = '0;
    bus_b.key_in   = '0;

    fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    build_sbox();
    model_sched(128'h0, zero_rk);
    zero_rk[0] = 128'h0;
    zero_rk[1] = 128'h62636363626363636263636362636363;
    zero_rk[2] = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    expect_quiet("reset");
    check_eq("reset_addr", 64'(bus_a.addr_wr), 64'd0);
    check_eq("reset_data", bus_a.key_round_wr, 64'd0);
    kill_n = 1'b1;

    // Idle for 50 cycles without a load
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      seen = seen | bus_a.en_wr | bus_a.key_ready | bus_a.busy | bus_b.en_wr | bus_b.busy;
      seen = seen | (|bus_a.key_round_wr) | (|bus_a.addr_wr);
    end
    check_eq("idle_quiet", 64'(seen), 64'd0);

    // FIPS-197 key: full schedule, both address bases
    load_key(FIPS_KEY);
    expect_writes(fips_rk, 22);
    expect_done();

    // Abort after 8 writes, reload with zero key at T+9
    @(negedge clk);
    load_key(FIPS_KEY);
    expect_writes(fips_rk, 8);
    load_key(128'h0);
    expect_writes(zero_rk, 22);
    expect_done();

    // Mid-expansion reset, with a simultaneous load that must be ignored
    load_key(FIPS_KEY);
    expect_writes(fips_rk, 14);
    kill_n = 1'b0;
    bus_a.key_load = 1'b1;
    bus_b.key_load = 1'b1;
    bus_a.key_in   = 128'h0;
    bus_b.key_in   = 128'h0;
    @(negedge clk);
    kill_n = 1'b1;
    bus_a.key_load = 1'b0;
    bus_b.key_load = 1'b0;
    expect_quiet("kill");
    check_eq("kill_addr", 64'(bus_a.addr_wr), 64'd0);
    check_eq("kill_data", bus_a.key_round_wr, 64'd0);
    for (int i = 0; i < 3; i++) @(negedge clk);
    expect_quiet("post_kill");
    load_key(FIPS_KEY);
    expect_writes(fips_rk, 22);
    expect_done();

    // Reload from DONE with model-checked keys
    for (int k = 0; k < 2; k++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom};
      model_sched(rkey, rand_rk);
      @(negedge clk);
      load_key(rkey);
      expect_writes(rand_rk, 22);
      expect_done();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
